// File: rtl/run_detector_if.sv
// ============================================================================
//  Module      : run_detector_if
//  Description : Stream/status bundle between a serial source and run_detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface run_detector_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_bit;
   logic             target_bit;
   logic             overlap;
   logic             clear_count;
   logic             out_bit;
   logic [7:0]       run_len;
   logic [CNT_W-1:0] match_count;
   logic             count_sat;

   modport master (
      output in_valid, in_bit, target_bit, overlap, clear_count,
      input  out_bit, run_len, match_count, count_sat
   );

   modport slave (
      input  in_valid, in_bit, target_bit, overlap, clear_count,
      output out_bit, run_len, match_count, count_sat
   );
endinterface

`default_nettype wire

// File: rtl/run_detector.sv
// ============================================================================
//  Module      : run_detector
//  Description : Flags runs of RUN_LEN consecutive target bits on a serial stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_detector #(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  wire logic       clk,
   input  wire logic       reset,
   run_detector_if.slave   bus
);

   if (RUN_LEN < 1 || RUN_LEN > 255) begin : g_bad_run_len
      $error("run_detector: RUN_LEN must be within 1..255");
   end

   localparam logic [7:0] c_RUN_LEN    = 8'(RUN_LEN);
   localparam logic [7:0] c_RUN_LEN_M1 = 8'(RUN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_MATCH = 2'd2
   } state_t;

   state_t           r_state;
   logic [7:0]       r_run_len;
   logic             r_out_bit;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   logic             w_hit;
   logic             w_evt;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_hit = bus.in_valid && (bus.in_bit == bus.target_bit);

   // A match event is any hit beat whose transition lands in MATCH.
   assign w_evt = w_hit &&
                  (((r_state == S_IDLE)  && (RUN_LEN == 1)) ||
                   ((r_state == S_RUN)   && (r_run_len == c_RUN_LEN_M1)) ||
                   ((r_state == S_MATCH) && bus.overlap));

   always_comb begin
      w_cnt_next = r_cnt;
      if (bus.clear_count) begin
         w_cnt_next = w_evt ? CNT_W'(1) : '0;
      end else if (w_evt && !(&r_cnt)) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_run_len <= 8'd0;
         r_out_bit <= 1'b0;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
      end else begin
         r_out_bit <= w_evt;
         r_cnt     <= w_cnt_next;
         r_sat     <= &w_cnt_next;
         if (bus.in_valid) begin
            case (r_state)
               S_IDLE: begin
                  if (w_hit) begin
                     r_run_len <= 8'd1;
                     r_state   <= (RUN_LEN == 1) ? S_MATCH : S_RUN;
                  end
               end
               S_RUN: begin
                  if (w_hit) begin
                     r_run_len <= r_run_len + 8'd1;
                     r_state   <= (r_run_len == c_RUN_LEN_M1) ? S_MATCH : S_RUN;
                  end else begin
                     r_run_len <= 8'd0;
                     r_state   <= S_IDLE;
                  end
               end
               S_MATCH: begin
                  // Legacy mode drops the beat after a match regardless of value.
                  if (w_hit && bus.overlap) begin
                     r_run_len <= c_RUN_LEN;
                     r_state   <= S_MATCH;
                  end else begin
                     r_run_len <= 8'd0;
                     r_state   <= S_IDLE;
                  end
               end
               default: begin
                  r_run_len <= 8'd0;
                  r_state   <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.out_bit     = r_out_bit;
   assign bus.run_len     = r_run_len;
   assign bus.match_count = r_cnt;
   assign bus.count_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_run_detector.sv
// ============================================================================
//  Module      : tb_run_detector
//  Description : Scoreboard bench for run_detector against a run-counting model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_detector;

   localparam int RUN_LEN = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic ob;
      int   rl;
      int   mc;
      logic sat;
   } exp_t;

   logic clk;
   logic reset;
   exp_t q[$];
   int   errors  = 0;
   int   checks  = 0;
   int   pushed  = 0;
   int   popped  = 0;
   bit   done    = 0;

   // reference state: length of the current target run and the match tally
   int   m_run = 0;
   int   m_cnt = 0;

   run_detector_if #(.CNT_W(CNT_W)) bus ();

   run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic beat(input logic v, input logic b, input logic t,
                       input logic o, input logic c);
      exp_t e;
      bit   evt;
      @(negedge clk);
      bus.in_valid    = v;
      bus.in_bit      = b;
      bus.target_bit  = t;
      bus.overlap     = o;
      bus.clear_count = c;
      evt = 0;
      if (v) begin
         if (b != t) begin
            m_run = 0;
         end else if (m_run == RUN_LEN) begin
            if (o) evt = 1;
            else   m_run = 0;
         end else begin
            m_run = m_run + 1;
            evt   = (m_run == RUN_LEN);
         end
      end
      if (c)                          m_cnt = evt ? 1 : 0;
      else if (evt && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      e.ob  = evt;
      e.rl  = m_run;
      e.mc  = m_cnt;
      e.sat = (m_cnt == CNT_MAX);
      q.push_back(e);
      pushed++;
   endtask

   task automatic hits(input int n, input logic t, input logic o);
      for (int i = 0; i < n; i++) beat(1'b1, t, t, o, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_bit"},     int'(bus.out_bit),     0);
      check({tag, "_run_len"},     int'(bus.run_len),     0);
      check({tag, "_match_count"}, int'(bus.match_count), 0);
      check({tag, "_count_sat"},   int'(bus.count_sat),   0);
   endtask

   // monitor: one expected entry per clock edge, compared just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            popped++;
            check("out_bit",     int'(bus.out_bit),     int'(e.ob));
            check("run_len",     int'(bus.run_len),     e.rl);
            check("match_count", int'(bus.match_count), e.mc);
            check("count_sat",   int'(bus.count_sat),   int'(e.sat));
         end
      end
   end

   initial begin
      reset           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_bit      = 1'b0;
      bus.target_bit  = 1'b1;
      bus.overlap     = 1'b0;
      bus.clear_count = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // legacy mode, eight ones: one pulse, fifth bit discarded
      hits(8, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      // overlap mode: pulse on beats 4..8
      hits(8, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      // target 0 with a break on the third beat
      beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      hits(4, 1'b0, 1'b0);
      beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // valid gaps do not break a run
      hits(2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      hits(2, 1'b1, 1'b0);
      beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // saturation, then clear coinciding with a match, then clear alone
      hits(20, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      hits(2, 1'b1, 1'b1);
      beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // asynchronous reset while run_len is 3
      hits(3, 1'b1, 1'b0);
      beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      m_run = 0;
      m_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      hits(4, 1'b1, 1'b0);
      beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // randomized traffic, biased toward hits so runs complete often
      for (int i = 0; i < 600; i++) begin
         logic t;
         logic b;
         t = ($urandom_range(0, 19) == 0) ? ~bus.target_bit : bus.target_bit;
         b = ($urandom_range(0, 3) == 0) ? ~t : t;
         beat(($urandom_range(0, 4) != 0), b, t,
              ($urandom_range(0, 7) == 0) ? ~bus.overlap : bus.overlap,
              ($urandom_range(0, 24) == 0));
      end
      beat(1'b0, 1'b0, bus.target_bit, bus.overlap, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #3;
      check("scoreboard_drained", popped, pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, popped %0d expected %0d",
               popped, pushed);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
